// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default timing for the key debounce array
// Purpose : per-channel FSM state encoding and default timing constants
//           (50 MHz system clock) shared by key_debounce_ch and key_debounce_array.
// Contents: key_fsm_t (RELEASED, PRESSED, LONG), DEF_* timing localparams.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LONG     = 2'd2
  } key_fsm_t;

  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_DEB_CYCLES    = 1_000_000;   // 20 ms
  localparam int DEF_LONG_CYCLES   = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms
  localparam int DEF_ACTIVE_LOW    = 1;

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - single key channel: sync, debounce, press/long/repeat events
// Purpose : one independent key channel. 2-flop synchroniser, polarity
//           normalisation, debounce counter, RELEASED/PRESSED/LONG FSM with
//           hold counter and optional auto-repeat counter.
// Macro   : KEY_AUTO_REPEAT_EN builds the repeat counter; otherwise
//           repeat_pulse is tied 0.
// Ports   : clk, rst_n (async, active-low)
//           key_in        raw asynchronous pin
//           key_state     debounced level, 1 = pressed
//           press_pulse   1-cycle pulse on accepted press
//           release_pulse 1-cycle pulse on accepted release
//           long_pulse    1-cycle pulse after LONG_CYCLES of hold
//           repeat_pulse  1-cycle auto-repeat pulse while in LONG
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
  // Raw pin level of a released key; the synchroniser resets to it so that
  // leaving reset never looks like an edge.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic sync_1, sync_2, level;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic accept, press_evt, release_evt, long_evt;
  key_fsm_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= IDLE_RAW;
      sync_2 <= IDLE_RAW;
    end else begin
      sync_1 <= key_in;
      sync_2 <= sync_1;
    end
  end

  assign level = sync_2 ^ IDLE_RAW;  // 1 = pressed

  // Change is accepted on the edge after the counter has seen DEB_CYCLES-1
  // increments with the level still differing.
  assign accept      = (level != key_state) && (deb_cnt == DEB_MAX);
  assign press_evt   = accept && level;
  assign release_evt = accept && !level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt       <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if ((level == key_state) || accept) deb_cnt <= '0;
      else                                deb_cnt <= deb_cnt + 1'b1;
      if (accept) key_state <= ~key_state;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RELEASED;
    else        state <= state_next;
  end

  // FSM next state; a release on the same edge as the long threshold wins.
  always_comb begin
    state_next = state;
    case (state)
      RELEASED: if (press_evt) state_next = PRESSED;
      PRESSED: begin
        if (release_evt)               state_next = RELEASED;
        else if (hold_cnt == HOLD_MAX) state_next = LONG;
      end
      LONG:     if (release_evt) state_next = RELEASED;
      default:  state_next = RELEASED;
    endcase
  end

  // FSM outputs (events registered below into 1-cycle pulses)
  always_comb begin
    long_evt = (state == PRESSED) && (state_next == LONG);
  end

  // Hold counter: 0 on the key_state rise edge, saturates at LONG_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_evt;
      if ((state == RELEASED) || release_evt)
        hold_cnt <= '0;
      else if ((state == PRESSED) && (hold_cnt != HOLD_MAX))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic rep_evt;

  // Counter starts at 0 on the edge entering LONG, so the first repeat lands
  // REPEAT_CYCLES after long_pulse. No repeat on the release edge itself.
  assign rep_evt = (state == LONG) && !release_evt && (rep_cnt == REP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_evt;
      if ((state != LONG) || rep_evt) rep_cnt <= '0;
      else                            rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - array of independent debounced key channels
// Purpose : NUM_KEYS copies of key_debounce_ch, one per key pin, no sharing.
// Macro   : KEY_AUTO_REPEAT_EN enables auto-repeat in every channel.
// Ports   : clk, rst_n (async, active-low)
//           key_in[NUM_KEYS]        raw asynchronous key pins
//           key_state[NUM_KEYS]     debounced level, 1 = pressed
//           press_pulse[NUM_KEYS]   accepted press pulses
//           release_pulse[NUM_KEYS] accepted release pulses
//           long_pulse[NUM_KEYS]    long-press pulses
//           repeat_pulse[NUM_KEYS]  auto-repeat pulses (0 unless macro defined)
module key_debounce_array
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_in        (key_in[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - directed self-checking bench for key_debounce_array
module tb_key_debounce_array;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // per-window event record for one channel, cycle index relative to stimulus
  int k_now, p_cnt, p_at, r_cnt, r_at, l_cnt, l_at, rp_cnt;
  int rp_at[$];
  bit ks_high, pr_both;

  key_debounce_array #(
    .NUM_KEYS(4), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec;
    k_now = 0; p_cnt = 0; p_at = -1; r_cnt = 0; r_at = -1;
    l_cnt = 0; l_at = -1; rp_cnt = 0; rp_at.delete();
    ks_high = 0; pr_both = 0;
  endtask

  task automatic watch(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      k_now++;
      if (press_pulse[ch])   begin p_cnt++; if (p_at < 0) p_at = k_now; end
      if (release_pulse[ch]) begin r_cnt++; if (r_at < 0) r_at = k_now; end
      if (long_pulse[ch])    begin l_cnt++; if (l_at < 0) l_at = k_now; end
      if (repeat_pulse[ch])  begin rp_cnt++; rp_at.push_back(k_now); end
      if (key_state[ch]) ks_high = 1;
      if (press_pulse[ch] && release_pulse[ch]) pr_both = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_in = 4'hF;
    step(); step();
    key_in[0] = 1'b0;  // pin activity during reset must be ignored
    step(); step(); step(); step(); step(); step(); step();
    n_checks++; if (key_state !== 4'h0) begin n_fail++; $display("FAIL reset_key_state: got %b expected 0000", key_state); end
    n_checks++; if (press_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_press: got %b expected 0000", press_pulse); end
    n_checks++; if (release_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_release: got %b expected 0000", release_pulse); end
    n_checks++; if (long_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_long: got %b expected 0000", long_pulse); end
    n_checks++; if (repeat_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_repeat: got %b expected 0000", repeat_pulse); end
    key_in = 4'hF;
    step();
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_press_latency;
    clear_rec();
    key_in[0] = 1'b0;
    watch(0, 5);
    n_checks++; if (key_state[0] !== 1'b0) begin n_fail++; $display("FAIL lat_state_before: got %b expected 0 at cycle 5", key_state[0]); end
    watch(0, 1);
    n_checks++; if (key_state[0] !== 1'b1) begin n_fail++; $display("FAIL lat_state_at6: got %b expected 1 at cycle 6", key_state[0]); end
    n_checks++; if (press_pulse[0] !== 1'b1) begin n_fail++; $display("FAIL lat_press_at6: got %b expected 1", press_pulse[0]); end
    watch(0, 4);
    n_checks++; if (p_cnt !== 1) begin n_fail++; $display("FAIL lat_press_count: got %0d expected 1", p_cnt); end
    n_checks++; if (r_cnt !== 0) begin n_fail++; $display("FAIL lat_release_count: got %0d expected 0", r_cnt); end
    n_checks++; if (key_in !== 4'hE || key_state !== 4'h1) begin n_fail++; $display("FAIL lat_other_channels: got key_state %b expected 0001", key_state); end
  endtask

  task automatic test_reset_mid_press;
    // key 0 still held and accepted from the previous test
    rst_n = 1'b0;
    #1;
    n_checks++; if (key_state !== 4'h0 || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin n_fail++; $display("FAIL midrst_async: got state %b press %b release %b expected all 0", key_state, press_pulse, release_pulse); end
    step(); step(); step();
    n_checks++; if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin n_fail++; $display("FAIL midrst_held: got state %b press %b release %b expected all 0", key_state, press_pulse, release_pulse); end
    rst_n = 1'b1;
    clear_rec();
    watch(0, 10);
    n_checks++; if (p_at !== 6 || p_cnt !== 1) begin n_fail++; $display("FAIL midrst_repress: got at %0d count %0d expected at 6 count 1", p_at, p_cnt); end
    n_checks++; if (r_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_release: got %0d expected 0", r_cnt); end
    clear_rec();
    key_in[0] = 1'b1;
    watch(0, 10);
    n_checks++; if (r_at !== 6 || r_cnt !== 1) begin n_fail++; $display("FAIL midrst_release: got at %0d count %0d expected at 6 count 1", r_at, r_cnt); end
    n_checks++; if (key_state[0] !== 1'b0 || l_cnt !== 0) begin n_fail++; $display("FAIL midrst_after: got state %b long %0d expected 0 0", key_state[0], l_cnt); end
  endtask

  task automatic test_bounce;
    clear_rec();
    for (int i = 0; i < 15; i++) begin
      key_in[1] = 1'b0; watch(1, 2);
      key_in[1] = 1'b1; watch(1, 2);
    end
    watch(1, 10);
    n_checks++; if (p_cnt !== 0 || r_cnt !== 0) begin n_fail++; $display("FAIL bounce_pulses: got press %0d release %0d expected 0 0", p_cnt, r_cnt); end
    n_checks++; if (ks_high !== 1'b0) begin n_fail++; $display("FAIL bounce_state: got %b expected 0", ks_high); end
    // 3-cycle glitch is one short of the debounce window
    clear_rec();
    key_in[1] = 1'b0; watch(1, 3);
    key_in[1] = 1'b1; watch(1, 10);
    n_checks++; if (p_cnt !== 0 || ks_high !== 1'b0) begin n_fail++; $display("FAIL glitch3: got press %0d state %b expected 0 0", p_cnt, ks_high); end
    // 4-cycle glitch is exactly long enough
    clear_rec();
    key_in[1] = 1'b0; watch(1, 4);
    key_in[1] = 1'b1; watch(1, 10);
    n_checks++; if (p_at !== 6 || r_at !== 10) begin n_fail++; $display("FAIL glitch4: got press at %0d release at %0d expected 6 10", p_at, r_at); end
    n_checks++; if (pr_both !== 1'b0) begin n_fail++; $display("FAIL glitch4_overlap: got %b expected 0", pr_both); end
  endtask

  task automatic test_long_press;
    clear_rec();
    key_in[2] = 1'b0;
    watch(2, 40);
    key_in[2] = 1'b1;
    watch(2, 15);
    n_checks++; if (p_at !== 6 || p_cnt !== 1) begin n_fail++; $display("FAIL long_press: got at %0d count %0d expected 6 1", p_at, p_cnt); end
    n_checks++; if (l_at !== 26 || l_cnt !== 1) begin n_fail++; $display("FAIL long_pulse: got at %0d count %0d expected 26 1", l_at, l_cnt); end
    n_checks++; if (r_at !== 46 || r_cnt !== 1) begin n_fail++; $display("FAIL long_release: got at %0d count %0d expected 46 1", r_at, r_cnt); end
`ifdef KEY_AUTO_REPEAT_EN
    n_checks++; if (rp_cnt !== 3) begin n_fail++; $display("FAIL repeat_count: got %0d expected 3", rp_cnt); end
    if (rp_cnt == 3) begin
      n_checks++; if (rp_at[0] !== 31 || rp_at[1] !== 36 || rp_at[2] !== 41) begin n_fail++; $display("FAIL repeat_times: got %0d %0d %0d expected 31 36 41", rp_at[0], rp_at[1], rp_at[2]); end
    end
`else
    n_checks++; if (rp_cnt !== 0) begin n_fail++; $display("FAIL repeat_absent: got %0d expected 0", rp_cnt); end
`endif
  endtask

  task automatic test_short_press;
    clear_rec();
    key_in[3] = 1'b0;
    watch(3, 10);
    key_in[3] = 1'b1;
    watch(3, 20);
    n_checks++; if (p_at !== 6 || p_cnt !== 1) begin n_fail++; $display("FAIL short_press: got at %0d count %0d expected 6 1", p_at, p_cnt); end
    n_checks++; if (r_at !== 16 || r_cnt !== 1) begin n_fail++; $display("FAIL short_release: got at %0d count %0d expected 16 1", r_at, r_cnt); end
    n_checks++; if (l_cnt !== 0 || rp_cnt !== 0) begin n_fail++; $display("FAIL short_no_long: got long %0d repeat %0d expected 0 0", l_cnt, rp_cnt); end
  endtask

  task automatic test_simultaneous;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) begin
        n_checks++; if (press_pulse !== 4'h0) begin n_fail++; $display("FAIL simul_early: got %b expected 0000", press_pulse); end
      end
      if (k == 6) begin
        n_checks++; if (press_pulse !== 4'h9) begin n_fail++; $display("FAIL simul_press: got %b expected 1001", press_pulse); end
      end
    end
    n_checks++; if (key_state !== 4'h9) begin n_fail++; $display("FAIL simul_state: got %b expected 1001", key_state); end
    key_in = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    n_checks++; if (release_pulse !== 4'h9) begin n_fail++; $display("FAIL simul_release: got %b expected 1001", release_pulse); end
    step();
    n_checks++; if (key_state !== 4'h0 || release_pulse !== 4'h0) begin n_fail++; $display("FAIL simul_idle: got state %b release %b expected 0000 0000", key_state, release_pulse); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_reset_mid_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
